// File: rtl/avalon_ram_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | avalon_ram_responder                                                       |
// | Avalon-style word RAM responder with programmable read/write wait states.  |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module avalon_ram_responder #(
   parameter int ADDR_WIDTH = 12,
   parameter int READ_WAIT  = 2,
   parameter int WRITE_WAIT = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        read,
   input  logic        write,
   input  logic [31:0] address,
   input  logic [3:0]  byteenable,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   output logic        waitrequest,
   output logic [31:0] read_count,
   output logic [31:0] write_count
);

   localparam int         c_depth     = 2 ** ADDR_WIDTH;
   localparam logic [3:0] c_read_lat  = 4'(READ_WAIT);
   localparam logic [3:0] c_write_lat = 4'(WRITE_WAIT);
   localparam logic [0:0] c_st_idle   = 1'b0;
   localparam logic [0:0] c_st_wait   = 1'b1;

   logic [0:0]            r_state;
   logic [0:0]            w_state_nxt;
   logic [3:0]            r_cnt;
   logic [3:0]            w_cnt_nxt;
   logic                  w_req;
   logic [3:0]            w_lat;
   logic                  w_complete;
   logic                  w_load_read;
   logic [ADDR_WIDTH-1:0] w_idx;
   logic [31:0]           w_init_word;
   logic [31:0]           w_mem_word;
   logic [31:0]           w_write_word;

   // Storage holds contents XOR the power-on image (16*i+1), so the all-zero
   // power-up state of the array already presents the required initial values.
   logic [31:0]           r_delta [c_depth];

   assign w_req       = read | write;
   assign w_lat       = write ? c_write_lat : c_read_lat;
   assign w_idx       = address[ADDR_WIDTH-1:0];
   assign w_init_word = (32'(w_idx) * 32'd16) + 32'd1;
   assign w_mem_word  = r_delta[w_idx] ^ w_init_word;

   generate
      if (ADDR_WIDTH < 32) begin : g_unused_addr
         logic w_unused_addr_bits;
         assign w_unused_addr_bits = ^address[31:ADDR_WIDTH];
      end
   endgenerate

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= c_st_idle;
         r_cnt   <= 4'd0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         c_st_idle: begin
            if (w_req) begin
               w_state_nxt = c_st_wait;
               w_cnt_nxt   = 4'd1;
            end
         end
         c_st_wait: begin
            // A master switching read/write mid-hold can leave cnt above LAT;
            // restarting is the only safe recovery.
            if (w_req && (r_cnt < w_lat)) begin
               w_cnt_nxt = r_cnt + 4'd1;
            end else begin
               w_state_nxt = c_st_idle;
               w_cnt_nxt   = 4'd0;
            end
         end
         default: begin
            w_state_nxt = c_st_idle;
            w_cnt_nxt   = 4'd0;
         end
      endcase
   end

   // Output logic
   always_comb begin
      waitrequest = w_req && (r_cnt != w_lat);
      w_complete  = w_req && (r_cnt == w_lat);
      w_load_read = read && !write && (w_cnt_nxt == w_lat);
   end

   always_comb begin
      w_write_word = w_mem_word;
      for (int b = 0; b < 4; b++) begin
         if (byteenable[b]) begin
            w_write_word[8*b +: 8] = writedata[8*b +: 8];
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         readdata    <= 32'd0;
         read_count  <= 32'd0;
         write_count <= 32'd0;
      end else begin
         if (w_load_read) begin
            readdata <= w_mem_word;
         end
         if (w_complete && write) begin
            write_count <= write_count + 32'd1;
         end
         if (w_complete && !write) begin
            read_count <= read_count + 32'd1;
         end
      end
   end

   // Contents survive reset; a reset mid-hold clears cnt so no completion occurs.
   always_ff @(posedge clk) begin
      if (reset && w_complete && write) begin
         r_delta[w_idx] <= w_write_word ^ w_init_word;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_avalon_ram_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_avalon_ram_responder                                                    |
// | Self-checking bench for avalon_ram_responder against a behavioural model.  |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module tb_avalon_ram_responder;

   localparam int AW = 12;
   localparam int RW = 2;
   localparam int WW = 1;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        read = 1'b0;
   logic        write = 1'b0;
   logic [31:0] address = 32'd0;
   logic [3:0]  byteenable = 4'd0;
   logic [31:0] writedata = 32'd0;
   logic [31:0] readdata;
   logic        waitrequest;
   logic [31:0] read_count;
   logic [31:0] write_count;

   int checks = 0;
   int errors = 0;

   logic [31:0] m_mem [2**AW];
   logic [31:0] m_rd;
   logic [31:0] m_rc;
   logic [31:0] m_wc;

   always #5 clk = ~clk;

   avalon_ram_responder #(
      .ADDR_WIDTH (AW),
      .READ_WAIT  (RW),
      .WRITE_WAIT (WW)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .read        (read),
      .write       (write),
      .address     (address),
      .byteenable  (byteenable),
      .writedata   (writedata),
      .readdata    (readdata),
      .waitrequest (waitrequest),
      .read_count  (read_count),
      .write_count (write_count)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic go_idle();
      read  = 1'b0;
      write = 1'b0;
      @(posedge clk);
      #1;
   endtask

   // Entered 1 time unit after a rising edge; leaves 1 unit after the edge
   // that ends the completion cycle, with the request still driven.
   task automatic do_txn(input string tag, input logic rd, input logic wr,
                         input logic [31:0] addr, input logic [3:0] be,
                         input logic [31:0] data);
      int          waits;
      bit          done;
      int          lat;
      int          idx;
      logic [31:0] word;
      waits      = 0;
      done       = 1'b0;
      read       = rd;
      write      = wr;
      address    = addr;
      byteenable = be;
      writedata  = data;
      lat        = wr ? WW : RW;
      idx        = int'(addr % (2**AW));
      #1;
      for (int i = 0; i < 40 && !done; i++) begin
         if (waitrequest) begin
            waits++;
            @(posedge clk);
            #2;
         end else begin
            done = 1'b1;
         end
      end
      if (!done) begin
         checks++;
         errors++;
         $error("FAIL %s_timeout: observed waitrequest stuck high, expected completion", tag);
         return;
      end
      check({tag, "_waits"}, 32'(waits), 32'(lat));
      if (wr) begin
         word = m_mem[idx];
         for (int b = 0; b < 4; b++) begin
            if (be[b]) word[8*b +: 8] = data[8*b +: 8];
         end
         m_mem[idx] = word;
         m_wc++;
      end else begin
         m_rd = m_mem[idx];
         m_rc++;
      end
      check({tag, "_rdata"}, readdata, m_rd);
      @(posedge clk);
      #1;
      check({tag, "_rcount"}, read_count, m_rc);
      check({tag, "_wcount"}, write_count, m_wc);
   endtask

   initial begin
      for (int i = 0; i < 2**AW; i++) m_mem[i] = 32'(16 * i + 1);
      m_rd = 32'd0;
      m_rc = 32'd0;
      m_wc = 32'd0;

      // Reset held with a read pending
      read    = 1'b1;
      address = 32'd16;
      @(posedge clk);
      @(posedge clk);
      #1;
      check("rst_readdata", readdata, 32'd0);
      check("rst_rcount", read_count, 32'd0);
      check("rst_wcount", write_count, 32'd0);
      check("rst_waitreq", 32'(waitrequest), 32'd1);

      // Release with the read still held: full READ_WAIT, then basic reads
      reset = 1'b1;
      do_txn("basic_rd16", 1'b1, 1'b0, 32'd16, 4'h0, 32'd0);
      check("basic_rd16_const", readdata, 32'd257);
      do_txn("basic_rd22", 1'b1, 1'b0, 32'd22, 4'h0, 32'd0);
      check("basic_rd22_const", readdata, 32'd353);
      go_idle();

      // Byte-enabled write and readback
      do_txn("bytewr5", 1'b0, 1'b1, 32'd5, 4'b0101, 32'hAABBCCDD);
      go_idle();
      do_txn("bytewr5_rb", 1'b1, 1'b0, 32'd5, 4'h0, 32'd0);
      check("bytewr5_const", readdata, 32'h00BB00DD);
      go_idle();

      // Aliased back-to-back reads
      do_txn("alias_1010", 1'b1, 1'b0, 32'h1010, 4'h0, 32'd0);
      check("alias_1010_const", readdata, 32'd257);
      do_txn("alias_0010", 1'b1, 1'b0, 32'h0010, 4'h0, 32'd0);
      check("alias_0010_const", readdata, 32'd257);
      go_idle();

      // Aborted read followed by a write
      read    = 1'b1;
      address = 32'd3;
      #1;
      check("abort_waitreq", 32'(waitrequest), 32'd1);
      @(posedge clk);
      #1;
      read = 1'b0;
      @(posedge clk);
      #1;
      check("abort_rcount", read_count, m_rc);
      check("abort_rdata", readdata, m_rd);
      do_txn("abort_wr", 1'b0, 1'b1, 32'd9, 4'hF, 32'hCAFEF00D);
      go_idle();

      // Randomised traffic over a small aliased address window
      for (int n = 0; n < 60; n++) begin
         int          sel;
         logic [31:0] a;
         sel = $urandom_range(0, 2);
         a   = ($urandom() & 32'hFFFF_F000) | 32'($urandom_range(0, 3));
         do_txn("rand", (sel != 1), (sel != 0), a, 4'($urandom_range(0, 15)), $urandom());
         if ($urandom_range(0, 1) == 1) go_idle();
      end
      go_idle();

      // Reset while a write is waiting
      write      = 1'b1;
      address    = 32'd7;
      byteenable = 4'hF;
      writedata  = 32'h12345678;
      #1;
      check("midrst_waitreq", 32'(waitrequest), 32'd1);
      reset = 1'b0;
      #1;
      check("midrst_waitreq_rst", 32'(waitrequest), 32'd1);
      @(posedge clk);
      #1;
      write = 1'b0;
      reset = 1'b1;
      m_rd  = 32'd0;
      m_rc  = 32'd0;
      m_wc  = 32'd0;
      @(posedge clk);
      #1;
      check("midrst_wcount", write_count, 32'd0);
      check("midrst_rcount", read_count, 32'd0);
      check("midrst_rdata", readdata, 32'd0);
      do_txn("midrst_rb7", 1'b1, 1'b0, 32'd7, 4'h0, 32'd0);
      check("midrst_rb7_const", readdata, 32'h71);
      go_idle();

      // Simultaneous read and write acts as a write
      do_txn("both_rw", 1'b1, 1'b1, 32'd7, 4'b0011, 32'h0000BEEF);
      check("both_rw_keep", readdata, 32'h71);
      go_idle();
      do_txn("both_rw_rb", 1'b1, 1'b0, 32'd7, 4'h0, 32'd0);
      check("both_rw_rb_const", readdata, 32'h0000BEEF);
      go_idle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
